// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: default sizing and the
// per-channel debounce state encoding.
package input_conditioner_pkg;

  localparam int DEFAULT_WIDTH           = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 8;

  // STABLE_* states mean the accepted level matches the sample. WAIT_*
  // states mean a candidate new level is being counted toward acceptance.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } chanState_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input channel. It contains a two-flop synchronizer, a
// four-state acceptance FSM and a saturating stability counter. Level and
// edge pulses are all registered, so raw_i has no combinational path to
// any output.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic sampleEn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic          syncMeta_q;
  logic          sample_q;
  chanState_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Bring the asynchronous raw level into the clock domain. The second
  // flop's output is the only version of the input that the FSM sees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta_q <= 1'b0;
      sample_q   <= 1'b0;
    end else begin
      syncMeta_q <= raw_i;
      sample_q   <= syncMeta_q;
    end
  end

  // FSM, counter, accepted level and pulse registers. Reset drops any
  // partially counted candidate, so a full debounce is needed afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LOW;
      count_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic. Leaving a STABLE state consumes the first stable
  // sample, so the count starts at 1. Acceptance happens on the sample that
  // arrives while the count equals DEBOUNCE_CYCLES-1, so the counter never
  // goes past that value. An opposite sample in a WAIT state aborts the wait
  // whether or not the strobe is high, and no pulse is produced.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LOW: begin
        count_d = '0;
        if (sample_q && sampleEn_i) begin
          state_d = WAIT_HIGH;
          count_d = ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sample_q) begin
          state_d = STABLE_LOW;
          count_d = '0;
        end else if (sampleEn_i) begin
          if (count_q == LAST_COUNT) begin
            state_d = STABLE_HIGH;
            count_d = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      STABLE_HIGH: begin
        count_d = '0;
        if (!sample_q && sampleEn_i) begin
          state_d = WAIT_LOW;
          count_d = ONE;
        end
      end
      WAIT_LOW: begin
        if (sample_q) begin
          state_d = STABLE_HIGH;
          count_d = '0;
        end else if (sampleEn_i) begin
          if (count_q == LAST_COUNT) begin
            state_d = STABLE_LOW;
            count_d = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      default: begin
        state_d = STABLE_LOW;
        count_d = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner. It uses one independent debounce
// channel per raw input bit. All channels share the clock, the reset and
// the sample strobe, so transitions on several channels at the same time
// produce pulses in the same cycle.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             sample_en,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  for (genvar ch = 0; ch < WIDTH; ch++) begin : gChannel
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uChannel (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (raw_in[ch]),
      .sampleEn_i(sample_en),
      .level_o   (level_out[ch]),
      .rise_o    (rise_pulse[ch]),
      .fall_o    (fall_pulse[ch])
    );
  end

endmodule
